// File: rtl/tank_game_pkg.sv
// rtl/tank_game_pkg.sv - shared state enum, column constants and location decoders for the tank game
package tank_game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLY,
        DONE
    } state_t;

    localparam int TANK1_COL_MIN = 5;
    localparam int TANK2_COL_MAX = 2;
    localparam int NUM_COLS      = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] col;
    } loc_col_t;

    // tank1 may only sit on bits 3..1; bit0, zero and multi-hot are not positions
    function automatic loc_col_t tank1_loc_to_col(input logic [3:0] loc);
        loc_col_t r;
        r.valid = 1'b1;
        case (loc)
            4'b1000: r.col = 3'(TANK1_COL_MIN + 2);
            4'b0100: r.col = 3'(TANK1_COL_MIN + 1);
            4'b0010: r.col = 3'(TANK1_COL_MIN);
            default: begin
                r.valid = 1'b0;
                r.col   = 3'd0;
            end
        endcase
        return r;
    endfunction

    // tank2 may only sit on bits 2..0; bit3, zero and multi-hot are not positions
    function automatic loc_col_t tank2_loc_to_col(input logic [3:0] loc);
        loc_col_t r;
        r.valid = 1'b1;
        case (loc)
            4'b0100: r.col = 3'(TANK2_COL_MAX);
            4'b0010: r.col = 3'(TANK2_COL_MAX - 1);
            4'b0001: r.col = 3'(TANK2_COL_MAX - 2);
            default: begin
                r.valid = 1'b0;
                r.col   = 3'd0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - clear/enable counter that strobes once every TICK_DIV enabled cycles
module tick_divider #(
    parameter int TICK_DIV = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shell_engine.sv
// rtl/shell_engine.sv - shell flight and hit resolution per turn; SHELL_POWER_EN enables power-limited range
module shell_engine
    import tank_game_pkg::*;
#(
    parameter int TICK_DIV = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fire_req,
    input  logic       turn,
    input  logic [3:0] tank1_location,
    input  logic [3:0] tank2_location,
    input  logic [1:0] tank1_life,
    input  logic [1:0] tank2_life,
    input  logic [2:0] power,
    output logic       busy,
    output logic       shell_valid,
    output logic [2:0] shell_col,
    output logic       hit1,
    output logic       hit2,
    output logic       turn_done
);

    state_t     state, state_next;
    loc_col_t   t1, t2;
    logic       accept, tick, shooter;
    logic       at_target, at_edge, exhausted, finish;
    logic [2:0] target_col, start_col, steps_left;

    assign t1 = tank1_loc_to_col(tank1_location);
    assign t2 = tank2_loc_to_col(tank2_location);

    // turn_done blocks the cycle in which the turn is still being handed over
    assign accept = (state == IDLE) && fire_req && !turn_done
                 && (tank1_life != 2'd0) && (tank2_life != 2'd0)
                 && t1.valid && t2.valid;

    assign start_col = turn ? (t2.col + 3'd1) : (t1.col - 3'd1);

    assign at_target = (shell_col == target_col);
    assign at_edge   = shooter ? (shell_col == 3'(NUM_COLS - 1)) : (shell_col == 3'd0);
`ifdef SHELL_POWER_EN
    assign exhausted = (steps_left == 3'd0);
`else
    assign exhausted = 1'b0;
`endif
    assign finish = tick && (at_target || exhausted || at_edge);

    assign busy        = (state != IDLE);
    assign shell_valid = (state == FLY);

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (state == FLY),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = FLY;
            FLY:     if (finish) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shooter    <= 1'b0;
            target_col <= 3'd0;
            steps_left <= 3'd0;
            shell_col  <= 3'd0;
            hit1       <= 1'b0;
            hit2       <= 1'b0;
            turn_done  <= 1'b0;
        end else begin
            hit1      <= 1'b0;
            hit2      <= 1'b0;
            turn_done <= (state == DONE);
            if (accept) begin
                shooter    <= turn;
                target_col <= turn ? t1.col : t2.col;
                steps_left <= power;
                shell_col  <= start_col;
            end else if (state == FLY && tick) begin
                if (at_target) begin
                    hit1 <= shooter;
                    hit2 <= !shooter;
                end else if (!exhausted && !at_edge) begin
                    shell_col <= shooter ? (shell_col + 3'd1) : (shell_col - 3'd1);
                    if (steps_left != 3'd0) steps_left <= steps_left - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shell_engine.sv
// tb/tb_shell_engine.sv - randomized self-checking bench for shell_engine against a step-level model
module tb_shell_engine;

    localparam int TICK = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       fire_req;
    logic       turn;
    logic [3:0] tank1_location, tank2_location;
    logic [1:0] tank1_life, tank2_life;
    logic [2:0] power;
    logic       busy, shell_valid, hit1, hit2, turn_done;
    logic [2:0] shell_col;

    int checks = 0;
    int errors = 0;

    bit m_accept, m_hit;
    int m_cols[$];
    int obs_hit_cyc, obs_done_cyc;

    always #5 clk = ~clk;

    shell_engine #(.TICK_DIV(TICK)) dut (
        .clk           (clk),
        .rst           (rst),
        .fire_req      (fire_req),
        .turn          (turn),
        .tank1_location(tank1_location),
        .tank2_location(tank2_location),
        .tank1_life    (tank1_life),
        .tank2_life    (tank2_life),
        .power         (power),
        .busy          (busy),
        .shell_valid   (shell_valid),
        .shell_col     (shell_col),
        .hit1          (hit1),
        .hit2          (hit2),
        .turn_done     (turn_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {busy, shell_valid, (shell_valid ? shell_col : 3'd0), hit1, hit2, turn_done};
    endfunction

    function automatic int t1_col(input logic [3:0] l);
        case (l)
            4'b1000: return 7;
            4'b0100: return 6;
            4'b0010: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic int t2_col(input logic [3:0] l);
        case (l)
            4'b0100: return 2;
            4'b0010: return 1;
            4'b0001: return 0;
            default: return -1;
        endcase
    endfunction

    // columns the shell visits, one per step, and whether the last one is the target
    task automatic model(input bit t, input logic [3:0] l1, input logic [3:0] l2,
                         input logic [1:0] f1, input logic [1:0] f2, input logic [2:0] p);
        int c1, c2, col, tgt, dir, steps;
        c1 = t1_col(l1);
        c2 = t2_col(l2);
        m_cols.delete();
        m_hit = 0;
        m_accept = (f1 != 0) && (f2 != 0) && (c1 >= 0) && (c2 >= 0);
        if (!m_accept) return;
        dir   = t ? 1 : -1;
        col   = t ? c2 + 1 : c1 - 1;
        tgt   = t ? c1 : c2;
        steps = int'(p);
`ifndef SHELL_POWER_EN
        steps = 1000;
`endif
        forever begin
            m_cols.push_back(col);
            if (col == tgt) begin
                m_hit = 1;
                break;
            end
            if (steps == 0 || col + dir < 0 || col + dir > 7) break;
            col += dir;
            steps--;
        end
    endtask

    task automatic run_shot(input string name, input bit t, input logic [3:0] l1, input logic [3:0] l2,
                            input logic [1:0] f1, input logic [1:0] f2, input logic [2:0] p,
                            input bit perturb);
        int e_rel;
        logic eb, ev, eh1, eh2, etd;
        logic [2:0] ec;
        model(t, l1, l2, f1, f2, p);
        turn = t; tank1_location = l1; tank2_location = l2;
        tank1_life = f1; tank2_life = f2; power = p;
        fire_req = 1'b1;
        step();
        fire_req = 1'b0;
        obs_hit_cyc = 0;
        obs_done_cyc = 0;
        if (!m_accept) begin
            for (int c = 1; c <= 3; c++) begin
                check($sformatf("%s_drop_c%0d", name, c), outs(), 8'd0);
                step();
            end
            return;
        end
        e_rel = TICK * m_cols.size();
        for (int c = 1; c <= e_rel + 2; c++) begin
            eb  = (c <= e_rel + 1);
            ev  = (c <= e_rel);
            ec  = ev ? 3'(m_cols[(c - 1) / TICK]) : 3'd0;
            eh1 = (c == e_rel + 1) && m_hit && t;
            eh2 = (c == e_rel + 1) && m_hit && !t;
            etd = (c == e_rel + 2);
            check($sformatf("%s_c%0d", name, c), outs(), {eb, ev, ec, eh1, eh2, etd});
            if ((hit1 || hit2) && obs_hit_cyc == 0) obs_hit_cyc = c;
            if (turn_done && obs_done_cyc == 0) obs_done_cyc = c;
            if (c == e_rel + 2) begin
                tank1_location = 4'b0100; tank2_location = 4'b0010;
                tank1_life = 2'd3; tank2_life = 2'd3;
                fire_req = 1'b1;
            end else if (perturb) begin
                fire_req = 1'($urandom_range(0, 1));
                tank1_location = 4'($urandom);
                tank2_location = 4'($urandom);
                tank1_life = 2'($urandom);
                tank2_life = 2'($urandom);
                power = 3'($urandom);
            end
            step();
        end
        fire_req = 1'b0;
        check({name, "_idle_after"}, outs(), 8'd0);
    endtask

    function automatic logic [3:0] rand_loc(input bit is_t1);
        logic [3:0] v;
        if ($urandom_range(0, 4) == 0) return 4'($urandom);
        case ($urandom_range(0, 2))
            0:       v = 4'b0010;
            1:       v = 4'b0100;
            default: v = is_t1 ? 4'b1000 : 4'b0001;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] rand_life();
        return ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
    endfunction

    initial begin
        rst = 1'b1; fire_req = 1'b1; turn = 1'b0;
        tank1_location = 4'b0100; tank2_location = 4'b0010;
        tank1_life = 2'd3; tank2_life = 2'd3; power = 3'd7;
        step();
        check("reset_c1", outs(), 8'd0);
        step();
        check("reset_c2", outs(), 8'd0);
        rst = 1'b0; fire_req = 1'b0;
        step();
        check("reset_fire_ignored", outs(), 8'd0);

`ifdef SHELL_POWER_EN
        run_shot("t1_full", 0, 4'b0100, 4'b0010, 3, 3, 7, 1);
`else
        run_shot("t1_full", 0, 4'b0100, 4'b0010, 3, 3, 0, 1);
`endif
        check("t1_full_hit_cyc", obs_hit_cyc, 21);
        check("t1_full_done_cyc", obs_done_cyc, 22);

`ifdef SHELL_POWER_EN
        run_shot("t1_short", 0, 4'b0100, 4'b0010, 3, 3, 1, 0);
        check("t1_short_hit_cyc", obs_hit_cyc, 0);
        check("t1_short_done_cyc", obs_done_cyc, 10);
        run_shot("t1_zero", 0, 4'b0100, 4'b0010, 3, 3, 0, 0);
        check("t1_zero_done_cyc", obs_done_cyc, 6);
`endif

        run_shot("t2_full", 1, 4'b1000, 4'b0001, 2, 1, 7, 1);
        check("t2_full_hit_cyc", obs_hit_cyc, 29);
        check("t2_full_done_cyc", obs_done_cyc, 30);

        run_shot("rej_life", 0, 4'b0100, 4'b0010, 3, 0, 7, 0);
        run_shot("rej_t1bit0", 0, 4'b0001, 4'b0010, 3, 3, 7, 0);
        run_shot("rej_multi", 1, 4'b0110, 4'b0010, 3, 3, 7, 0);
        run_shot("rej_zero", 1, 4'b0100, 4'b0000, 3, 3, 7, 0);

        turn = 1'b0; tank1_location = 4'b0100; tank2_location = 4'b0010;
        tank1_life = 2'd3; tank2_life = 2'd3; power = 3'd7;
        fire_req = 1'b1;
        step();
        fire_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        check("rst_mid", outs(), 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            check($sformatf("rst_mid_quiet_%0d", i), outs(), 8'd0);
        end

        for (int n = 0; n < 40; n++) begin
            run_shot($sformatf("rnd%0d", n), 1'($urandom), rand_loc(1), rand_loc(0),
                     rand_life(), rand_life(), 3'($urandom), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
